adder_sweep_checker: RTL
========================

Name: adder_sweep_checker

Overview:
- Self-checking stimulus/response engine for the WIDTH-bit adder (full_adder_10_bit and equivalents): the counterpart that drives the adder's A/B inputs and consumes its Sum/Carry outputs.
- Generates the exhaustive A×B sweep in hardware (replacing file-driven stimulus) and compares every result against an internally computed expected value.
- Reports pass/fail, error count and first failing vector; usable in simulation benches and on-chip BIST wrappers.

Parameters:
- WIDTH, 10, operand width; the sweep covers 2^(2*WIDTH) vectors.
- DUT_LAT, 0, DUT latency in clk cycles from a_out/b_out to sum_in/carry_in; legal range 0..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begins a sweep when sampled high in IDLE or DONE; ignored otherwise.
- a_out  output  WIDTH  operand A to the DUT.
- b_out  output  WIDTH  operand B to the DUT.
- sum_in  input  WIDTH  DUT sum.
- carry_in  input  1  DUT carry-out.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high (level) in DONE.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching vectors.
- first_err_valid  output  1  a mismatch has been recorded.
- first_err_a  output  WIDTH  A of the first mismatch.
- first_err_b  output  WIDTH  B of the first mismatch.

Behaviour:
- Reset: state=IDLE; all outputs 0. Reset mid-sweep aborts immediately and clears everything.
- States: IDLE -(start)-> RUN -(last vector issued)-> DRAIN -(DUT_LAT cycles)-> DONE -(start)-> RUN. If DUT_LAT=0, go RUN->DONE directly.
- Entry into RUN, from IDLE or DONE: a_out=b_out=0; clear err_count, first_err_*, and pass.
- RUN issues one vector per cycle. b_out increments every cycle. On b_out wrap (all-ones to 0), a_out increments. The vector with a_out=b_out=all-ones is the last.
- On leaving RUN, a_out/b_out hold their final values.
- Expected value: (WIDTH+1)-bit zero-extended a_out + b_out, computed on the issued vector.
- Expected value, with its A/B tags and a valid bit, passes through a DUT_LAT-deep shift register.
- Compare point: at the edge ending cycle k+DUT_LAT, {carry_in,sum_in} is compared with the entry issued in cycle k. Compare only when that entry's valid bit is set.
- Valid bits are 0 in IDLE/DRAIN/DONE, so no garbage compares.
- On mismatch:
  - err_count increments, saturating at all-ones (unreachable for legal WIDTH; still required).
  - If first_err_valid=0, latch the tags into first_err_a/b and set first_err_valid.
- DONE holds all results stable until start or rst. pass = (err_count==0), registered on entry to DONE.
- Timing: with start sampled at edge 0, the first vector appears after edge 1. done rises after edge 2^(2*WIDTH)+DUT_LAT+1.
- start while busy: ignored, no restart. start and rst together: rst wins.

Decomposition:
- Shared package adder_chk_pkg holds:
  - the state enum: IDLE, RUN, DRAIN, DONE;
  - the DUT_LAT_MAX=4 constant;
  - the expected-entry struct: valid, a, b, exp[WIDTH:0].
- One natural sub-module: chk_delay_line, a parameterised DUT_LAT-deep shift register of expected entries, with a pass-through when DUT_LAT=0.

Test Plan:
- rst held 3 cycles, then released with start=0 -> all outputs 0, state IDLE, a_out/b_out stay 0.
- WIDTH=4, DUT_LAT=0, correct combinational adder, start pulse -> done after edge 257, err_count=0, pass=1, first_err_valid=0.
- WIDTH=4, DUT_LAT=0, adder with sum[0] stuck-at-0 -> err_count=128, pass=0, first_err_a=0, first_err_b=1.
- WIDTH=4, DUT_LAT=0, carry forced 0 -> err_count=120, first_err_a=1, first_err_b=15.
- WIDTH=4, DUT_LAT=2, adder registered twice -> pass=1, done after edge 259. Same DUT with DUT_LAT=0 -> pass=0, err_count>0.
- WIDTH=4: rst asserted mid-RUN at vector (5,7) -> next cycle IDLE, all outputs 0. A start pulse during RUN is ignored: done timing unchanged. A new start in DONE clears results and reruns.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// Shared types for the adder sweep checker: FSM states, the
// expected-result entry carried down the latency-matching line.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_e;

    localparam int DUT_LAT_MAX = 4;

    // Entries are sized for the widest supported operand so one
    // type serves every WIDTH; unused upper bits are always zero.
    localparam int CHK_W_MAX = 16;

    typedef struct packed {
        logic                 valid;
        logic [CHK_W_MAX-1:0] a;
        logic [CHK_W_MAX-1:0] b;
        logic [CHK_W_MAX:0]   exp;
    } chk_entry_t;

    function automatic chk_entry_t mk_entry(
        input logic                 v,
        input logic [CHK_W_MAX-1:0] a,
        input logic [CHK_W_MAX-1:0] b
    );
        chk_entry_t e;
        e.valid = v;
        e.a     = a;
        e.b     = b;
        e.exp   = {1'b0, a} + {1'b0, b};
        return e;
    endfunction

endpackage

// File: rtl/adder_sweep_checker_delay.sv
// DEPTH-deep shift register of expected entries, aligning each
// issued vector with the DUT result it produces.
module chk_delay_line
    import adder_chk_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  chk_entry_t i_entry,
    output chk_entry_t o_entry
);

    localparam int SLOTS = (DEPTH > 0) ? DEPTH : 1;
    localparam int LAST  = SLOTS - 1;

    chk_entry_t r_pipe [SLOTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_entry;
            for (int i = 1; i < SLOTS; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Zero latency means compare against the vector on the wires now.
    assign o_entry = (DEPTH == 0) ? i_entry : r_pipe[LAST];

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive A x B sweep generator and result checker for a
// WIDTH-bit adder with DUT_LAT cycles of latency.
module adder_sweep_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*WIDTH:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b
);

    localparam int CW = 2 * WIDTH + 1;
    localparam logic [2:0] LAT_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    chk_state_e r_state;
    chk_state_e w_next;

    logic             r_go;
    logic [2:0]       r_drain;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_err;
    logic             r_pass;
    logic             r_fev;
    logic [WIDTH-1:0] r_fa;
    logic [WIDTH-1:0] r_fb;

    logic             w_last;
    chk_entry_t       w_issue;
    chk_entry_t       w_tail;
    logic [WIDTH:0]   w_dut;
    logic             w_tag_bad;
    logic             w_mismatch;
    logic [CW-1:0]    w_err_next;
    logic             w_enter_done;

    assign w_last = (&r_a) & (&r_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_go) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = (DUT_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (r_drain == LAT_LAST) w_next = DONE;
            end
            DONE: begin
                if (r_go) w_next = RUN;
            end
        endcase
    end

    assign w_issue = mk_entry(r_state == RUN,
                              CHK_W_MAX'(r_a),
                              CHK_W_MAX'(r_b));

    chk_delay_line #(
        .DEPTH (DUT_LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_entry (w_issue),
        .o_entry (w_tail)
    );

    // A tag with bits above WIDTH can only come from a corrupted entry.
    assign w_dut     = {carry_in, sum_in};
    assign w_tag_bad = ((w_tail.a >> WIDTH) != '0) ||
                       ((w_tail.b >> WIDTH) != '0);
    assign w_mismatch = w_tail.valid &&
                        ((w_tail.exp != (CHK_W_MAX + 1)'(w_dut)) ||
                         w_tag_bad);

    always_comb begin
        w_err_next = r_err;
        if (w_mismatch && !(&r_err)) begin
            w_err_next = r_err + 1'b1;
        end
    end

    assign w_enter_done = (w_next == DONE) && (r_state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_go    <= 1'b0;
            r_drain <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
            r_fev   <= 1'b0;
            r_fa    <= '0;
            r_fb    <= '0;
        end else begin
            r_go <= start && !r_go &&
                    ((r_state == IDLE) || (r_state == DONE));
            if (r_go) begin
                r_drain <= '0;
                r_a     <= '0;
                r_b     <= '0;
                r_err   <= '0;
                r_pass  <= 1'b0;
                r_fev   <= 1'b0;
                r_fa    <= '0;
                r_fb    <= '0;
            end else begin
                if ((r_state == RUN) && !w_last) begin
                    r_b <= r_b + 1'b1;
                    if (&r_b) r_a <= r_a + 1'b1;
                end
                if (r_state == DRAIN) begin
                    r_drain <= r_drain + 1'b1;
                end
                r_err <= w_err_next;
                if (w_mismatch && !r_fev) begin
                    r_fev <= 1'b1;
                    r_fa  <= w_tail.a[WIDTH-1:0];
                    r_fb  <= w_tail.b[WIDTH-1:0];
                end
                if (w_enter_done) begin
                    r_pass <= (w_err_next == '0);
                end
            end
        end
    end

    assign a_out           = r_a;
    assign b_out           = r_b;
    assign busy            = (r_state == RUN) || (r_state == DRAIN);
    assign done            = (r_state == DONE);
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_valid = r_fev;
    assign first_err_a     = r_fa;
    assign first_err_b     = r_fb;

endmodule
